// File: rtl/cache_pkg.sv
// Constants and FSM encoding shared between the L1 and the L2 cache.
// No logic, no latency, no flow control.
package cache_pkg;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 17;
    localparam int TAG_W      = 6;
    localparam int BLOCK_W    = 34;
    localparam int NUM_BLOCKS = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_EVICT   = 3'd2,
        ST_FILL    = 3'd3,
        ST_RESPOND = 3'd4
    } state_t;
endpackage

// File: rtl/l2_lru_age.sv
// Age-based LRU tracker; ages update on the edge after touch, victim_idx is combinational.
// No backpressure: a touch is always absorbed in one cycle.
module l2_lru_age #(
    parameter int NUM_BLOCKS = cache_pkg::NUM_BLOCKS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          touch,
    input  logic [$clog2(NUM_BLOCKS)-1:0] touch_idx,
    input  logic [NUM_BLOCKS-1:0]         invalid_mask,
    output logic [$clog2(NUM_BLOCKS)-1:0] victim_idx
);
    localparam int IW = $clog2(NUM_BLOCKS);

    logic [IW-1:0] age [NUM_BLOCKS];

    // Ages stay a permutation: the touched entry drops to 0, younger ones shift up by one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                age[i] <= i[IW-1:0];
            end
        end else if (touch) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                if (i[IW-1:0] == touch_idx) begin
                    age[i] <= '0;
                end else if (age[i] < age[touch_idx]) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic found;
        found      = 1'b0;
        victim_idx = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (invalid_mask[i] && !found) begin
                found      = 1'b1;
                victim_idx = i[IW-1:0];
            end
        end
        if (!found) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                if (age[i] == {IW{1'b1}}) begin
                    victim_idx = i[IW-1:0];
                end
            end
        end
    end
endmodule

// File: rtl/cache_l2_assoc.sv
// Fully associative write-back L2; hit acks 2 cycles after the request is sampled, misses wait on memory.
// L1 holds l1_req until l1_ack; memory stalls hold the FSM in EVICT/FILL with all mem_* stable.
module cache_l2_assoc #(
    parameter int ADDR_W     = cache_pkg::ADDR_W,
    parameter int DATA_W     = cache_pkg::DATA_W,
    parameter int NUM_BLOCKS = cache_pkg::NUM_BLOCKS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  l1_req,
    input  logic                  l1_wren,
    input  logic [ADDR_W-1:0]     l1_addr,
    input  logic [DATA_W-1:0]     l1_wdata,
    output logic                  l1_ack,
    output logic                  l1_hit,
    output logic [2*DATA_W-1:0]   l1_rdata,
    output logic                  mem_req,
    output logic                  mem_wren,
    output logic [ADDR_W-2:0]     mem_addr,
    output logic [2*DATA_W-1:0]   mem_wdata,
    input  logic [2*DATA_W-1:0]   mem_rdata,
    input  logic                  mem_ack
);
    localparam int TW = ADDR_W - 1;
    localparam int BW = 2 * DATA_W;
    localparam int IW = $clog2(NUM_BLOCKS);

    cache_pkg::state_t state, state_nxt;

    logic [ADDR_W-1:0]     req_addr;
    logic                  req_wren;
    logic [DATA_W-1:0]     req_wdata;
    logic [NUM_BLOCKS-1:0] valid, dirty;
    logic [TW-1:0]         tags [NUM_BLOCKS];
    logic [BW-1:0]         data [NUM_BLOCKS];
    logic [IW-1:0]         vic_q, resp_idx, hit_idx, victim_idx, touch_idx;
    logic                  hit, hit_q, touch, mem_fire;
    logic [TW-1:0]         req_tag;
    logic                  req_off;

    assign req_tag  = req_addr[ADDR_W-1:1];
    assign req_off  = req_addr[0];
    assign mem_fire = mem_req && mem_ack;

    function automatic logic [BW-1:0] merge_word(input logic [BW-1:0] blk, input logic off,
                                                 input logic [DATA_W-1:0] w);
        logic [BW-1:0] r;
        r = blk;
        if (off) r[BW-1:DATA_W] = w;
        else     r[DATA_W-1:0]  = w;
        return r;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (valid[i] && tags[i] == req_tag) begin
                hit     = 1'b1;
                hit_idx = i[IW-1:0];
            end
        end
    end

    // The victim is frozen into vic_q at LOOKUP so the fill lands where the eviction happened.
    assign touch     = (state == cache_pkg::ST_LOOKUP && hit) || (state == cache_pkg::ST_FILL && mem_fire);
    assign touch_idx = (state == cache_pkg::ST_LOOKUP) ? hit_idx : vic_q;

    l2_lru_age #(.NUM_BLOCKS(NUM_BLOCKS)) u_lru (
        .clk          (clk),
        .reset        (reset),
        .touch        (touch),
        .touch_idx    (touch_idx),
        .invalid_mask (~valid),
        .victim_idx   (victim_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= cache_pkg::ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            cache_pkg::ST_IDLE:    if (l1_req && !l1_ack) state_nxt = cache_pkg::ST_LOOKUP;
            cache_pkg::ST_LOOKUP: begin
                if (hit)                                          state_nxt = cache_pkg::ST_RESPOND;
                else if (valid[victim_idx] && dirty[victim_idx])  state_nxt = cache_pkg::ST_EVICT;
                else                                              state_nxt = cache_pkg::ST_FILL;
            end
            cache_pkg::ST_EVICT:   if (mem_fire) state_nxt = cache_pkg::ST_FILL;
            cache_pkg::ST_FILL:    if (mem_fire) state_nxt = cache_pkg::ST_RESPOND;
            cache_pkg::ST_RESPOND: state_nxt = cache_pkg::ST_IDLE;
            default:               state_nxt = cache_pkg::ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_addr  <= '0;
            req_wren  <= 1'b0;
            req_wdata <= '0;
            valid     <= '0;
            dirty     <= '0;
            vic_q     <= '0;
            resp_idx  <= '0;
            hit_q     <= 1'b0;
            l1_ack    <= 1'b0;
            l1_hit    <= 1'b0;
            l1_rdata  <= '0;
            mem_req   <= 1'b0;
            mem_wren  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
        end else begin
            l1_ack <= 1'b0;
            case (state)
                cache_pkg::ST_IDLE: begin
                    // The ack cycle still sees l1_req high; never treat it as a new request.
                    if (l1_req && !l1_ack) begin
                        req_addr  <= l1_addr;
                        req_wren  <= l1_wren;
                        req_wdata <= l1_wdata;
                    end
                end
                cache_pkg::ST_LOOKUP: begin
                    vic_q <= victim_idx;
                    if (hit) begin
                        hit_q    <= 1'b1;
                        resp_idx <= hit_idx;
                        if (req_wren) begin
                            data[hit_idx]  <= merge_word(data[hit_idx], req_off, req_wdata);
                            dirty[hit_idx] <= 1'b1;
                        end
                    end else begin
                        hit_q    <= 1'b0;
                        resp_idx <= victim_idx;
                        mem_req  <= 1'b1;
                        if (valid[victim_idx] && dirty[victim_idx]) begin
                            mem_wren  <= 1'b1;
                            mem_addr  <= tags[victim_idx];
                            mem_wdata <= data[victim_idx];
                        end else begin
                            mem_wren <= 1'b0;
                            mem_addr <= req_tag;
                        end
                    end
                end
                cache_pkg::ST_EVICT: begin
                    if (mem_fire) begin
                        mem_req  <= 1'b0;
                        mem_wren <= 1'b0;
                    end
                end
                cache_pkg::ST_FILL: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_wren <= 1'b0;
                        mem_addr <= req_tag;
                    end else if (mem_ack) begin
                        mem_req      <= 1'b0;
                        valid[vic_q] <= 1'b1;
                        dirty[vic_q] <= req_wren;
                        tags[vic_q]  <= req_tag;
                        data[vic_q]  <= req_wren ? merge_word(mem_rdata, req_off, req_wdata) : mem_rdata;
                    end
                end
                cache_pkg::ST_RESPOND: begin
                    l1_ack   <= 1'b1;
                    l1_hit   <= hit_q;
                    l1_rdata <= data[resp_idx];
                end
                default: ;
            endcase
        end
    end
endmodule
